// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_ctrl
//  Purpose  : E-stage multiply/divide controller. Latches mult/multu/div/divu
//             results into pending registers, holds a fixed-latency busy
//             window, then commits them to HI/LO. Handles mthi/mtlo,
//             mfhi/mflo read-out and the F/D stall request.
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,   // busy cycles for mult/multu (1..15)
  parameter int DIV_CYCLES  = 10   // busy cycles for div/divu   (1..15)
) (
  input  logic        clk,
  input  logic        reset,       // asynchronous, active low
  input  logic [3:0]  E_MDU_Op,
  input  logic        E_Start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [1:0]  E_MFSel,
  input  logic        D_UseMDU,
  output logic        E_Busy,
  output logic        E_Stall,
  output logic [31:0] E_MDU_O,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_BUSY = 1'b1;

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MTHI  = 4'd5;
  localparam logic [3:0] c_OP_MTLO  = 4'd6;

  localparam logic [1:0] c_MF_HI = 2'd1;
  localparam logic [1:0] c_MF_LO = 2'd2;

  localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_wr;   // cleared for divide-by-zero so HI/LO are left untouched

  // ---------------------------------------------------------------------------
  // Arithmetic, evaluated from the operands presented in the start cycle.
  // Products are formed on 64-bit zero/sign-extended operands so the low
  // 64 bits of the unsigned product equal the true signed/unsigned result.
  // ---------------------------------------------------------------------------
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_zero;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_den_s;
  logic [31:0] w_den_u;
  logic [31:0] w_uq_s;
  logic [31:0] w_ur_s;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;

  assign w_prod_s   = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
  assign w_prod_u   = {32'd0, E_A} * {32'd0, E_B};
  assign w_div_zero = (E_B == 32'd0);

  // Signed divide via magnitudes; quotient truncates toward zero and the
  // remainder takes the dividend's sign. 0x80000000 / -1 wraps to 0x80000000.
  assign w_abs_a = E_A[31] ? (~E_A + 32'd1) : E_A;
  assign w_abs_b = E_B[31] ? (~E_B + 32'd1) : E_B;
  // Substitute a divisor of 1 on zero so the datapath never sees x/0.
  assign w_den_s = w_div_zero ? 32'd1 : w_abs_b;
  assign w_den_u = w_div_zero ? 32'd1 : E_B;
  assign w_uq_s  = w_abs_a / w_den_s;
  assign w_ur_s  = w_abs_a % w_den_s;
  assign w_q_s   = (E_A[31] ^ E_B[31]) ? (~w_uq_s + 32'd1) : w_uq_s;
  assign w_r_s   = E_A[31] ? (~w_ur_s + 32'd1) : w_ur_s;
  assign w_q_u   = E_A / w_den_u;
  assign w_r_u   = E_A % w_den_u;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_wr;
  logic [3:0]  w_res_cnt;
  logic        w_is_long;

  // Select the pending result and busy length for the op in E.
  always_comb begin
    w_res_hi  = 32'd0;
    w_res_lo  = 32'd0;
    w_res_wr  = 1'b0;
    w_res_cnt = 4'd0;
    w_is_long = 1'b0;
    case (E_MDU_Op)
      c_OP_MULT: begin
        w_res_hi  = w_prod_s[63:32];
        w_res_lo  = w_prod_s[31:0];
        w_res_wr  = 1'b1;
        w_res_cnt = c_MULT_CNT;
        w_is_long = 1'b1;
      end
      c_OP_MULTU: begin
        w_res_hi  = w_prod_u[63:32];
        w_res_lo  = w_prod_u[31:0];
        w_res_wr  = 1'b1;
        w_res_cnt = c_MULT_CNT;
        w_is_long = 1'b1;
      end
      c_OP_DIV: begin
        w_res_hi  = w_r_s;
        w_res_lo  = w_q_s;
        w_res_wr  = ~w_div_zero;
        w_res_cnt = c_DIV_CNT;
        w_is_long = 1'b1;
      end
      c_OP_DIVU: begin
        w_res_hi  = w_r_u;
        w_res_lo  = w_q_u;
        w_res_wr  = ~w_div_zero;
        w_res_cnt = c_DIV_CNT;
        w_is_long = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Controller state, busy counter, pending results and HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= c_ST_IDLE;
      r_cnt     <= 4'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (E_Start) begin
            if (w_is_long) begin
              r_pend_hi <= w_res_hi;
              r_pend_lo <= w_res_lo;
              r_pend_wr <= w_res_wr;
              r_cnt     <= w_res_cnt;
              r_state   <= c_ST_BUSY;
            end else if (E_MDU_Op == c_OP_MTHI) begin
              r_hi <= E_A;
            end else if (E_MDU_Op == c_OP_MTLO) begin
              r_lo <= E_A;
            end
          end
        end
        c_ST_BUSY: begin
          // New ops are not accepted here; the hazard unit holds them in D.
          if (r_cnt == 4'd1) begin
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_cnt   <= 4'd0;
            r_state <= c_ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign E_Busy  = (r_state == c_ST_BUSY);
  // E_Start term covers the start cycle before E_Busy has risen.
  assign E_Stall = D_UseMDU && (E_Start || E_Busy);
  assign E_HI    = r_hi;
  assign E_LO    = r_lo;

  // HI/LO read-out for mfhi/mflo.
  always_comb begin
    E_MDU_O = 32'd0;
    case (E_MFSel)
      c_MF_HI: E_MDU_O = r_hi;
      c_MF_LO: E_MDU_O = r_lo;
      default: E_MDU_O = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- E-stage multiply/divide controller: accepts mult/multu/div/divu/mthi/mtlo from the E stage.
- Sequences a fixed-latency busy window and owns the HI/LO registers.
- Drives the stall request that the hazard unit uses to freeze F/D while an HI/LO-using instruction sits in D.
- Provides the HI/LO read value selected by mfhi/mflo to the E-stage result path, alongside the ALU result and the RegDst selection.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- E_MDU_Op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; other codes = none
- E_Start  input  1  E-stage instruction is a valid (non-bubble) MDU op
- E_A  input  32  rs operand (forwarded)
- E_B  input  32  rt operand (forwarded)
- E_MFSel  input  2  0 none, 1 mfhi, 2 mflo
- D_UseMDU  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- E_Busy  output  1  multi-cycle operation in progress
- E_Stall  output  1  stall request to hazard unit
- E_MDU_O  output  32  HI (mfhi), LO (mflo), else 0
- E_HI  output  32  architectural HI
- E_LO  output  32  architectural LO

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; counter 0; HI=LO=0; pending result registers 0.
  - E_Busy=0.
  - E_Stall=D_UseMDU && E_Start (combinational; with both inputs 0, it is 0).
- States:
  - IDLE: counter=0.
  - BUSY: counter 1..15 counts remaining cycles.
- IDLE, rising edge with E_Start=1:
  - op 1..4:
    - Compute the result from E_A/E_B in that cycle and latch it into pending registers.
    - Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
    - Go to BUSY.
  - op 5: HI<=E_A at this edge; stay IDLE; no busy.
  - op 6: LO<=E_A at this edge; stay IDLE; no busy.
  - op 0 or illegal: no action.
- BUSY, each rising edge:
  - counter decrements.
  - When counter==1 at the edge: HI/LO <= pending, counter<=0, go to IDLE.
  - E_Start is ignored in BUSY; the hazard unit guarantees none arrives.
- Latency: E_Start sampled at edge k → E_Busy=1 for exactly N cycles (k..k+N-1 edges) → new HI/LO visible after edge k+N.
- E_Busy = (state==BUSY). It is registered, with no combinational path from inputs.
- E_Stall = D_UseMDU && (E_Start || E_Busy).
  - Covers the start cycle before E_Busy rises.
  - Deasserts in the same cycle in which HI/LO become valid.
- Arithmetic:
  - mult: signed 32x32 → 64-bit; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 → 64-bit; HI=[63:32], LO=[31:0].
  - div: LO=quotient truncated toward zero, HI=remainder with sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (div): LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divisor 0 (div/divu): timing unchanged (full DIV_CYCLES busy); HI and LO keep their old values at completion.
- E_MDU_O: combinational read of current HI/LO per E_MFSel. During BUSY it returns the old values; stall prevents any mf* from reaching E.
- Reset mid-operation: aborts immediately; pending result discarded; HI=LO=0; E_Busy=0 with no completion write.

Test Plan:
- Reset release, idle inputs → E_Busy=0, E_Stall=0, E_HI=E_LO=0, E_MDU_O=0.
- mult E_A=3, E_B=0xFFFFFFFE → E_Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu same operands → HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- divu 7/2 → busy 10 cycles; LO=3, HI=1.
- div 0xFFFFFFF9/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Hazard check: D_UseMDU=1 (mflo) held from the E_Start cycle → E_Stall=1 for the start cycle plus all 10 busy cycles, 0 the cycle LO is valid; E_MFSel=2 then returns the new LO.
- Hazard check: D_UseMDU=0 throughout → E_Stall stays 0 while E_Busy=1.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive edges → no busy; HI/LO updated one edge each.
- Divisor-zero case: divu 5/0 with HI=0xA, LO=0xB → E_Busy high 10 cycles; HI/LO remain 0xA/0xB.
- Reset-abort case: assert reset in busy cycle 3 of a mult → HI=LO=0 and E_Busy=0 immediately (asynchronous); after release, no late write.
